// File: rtl/bram_pkg.sv
// bram_pkg: shared constants and helpers for the bram_dp dual-port RAM family.
// Latency: n/a (combinational helper functions and constants only).
// Backpressure: n/a.
package bram_pkg;

    // Legal READ_LAT range for bram_dp.
    localparam int BRAM_LAT_MIN = 1;
    localparam int BRAM_LAT_MAX = 3;

    // Widest data word bram_merge handles; callers zero-pad up to this width.
    localparam int BRAM_MAXW = 256;

    // Even parity: the stored bit makes the total count of ones in {byte, bit} even.
    function automatic logic bram_parity(input logic [7:0] b);
        return ^b;
    endfunction

    // Byte-enable merge: byte i comes from new_w when be[i] is set, else from old_w.
    function automatic logic [BRAM_MAXW-1:0] bram_merge(
        input logic [BRAM_MAXW-1:0]   old_w,
        input logic [BRAM_MAXW-1:0]   new_w,
        input logic [BRAM_MAXW/8-1:0] be
    );
        logic [BRAM_MAXW-1:0] r;
        r = old_w;
        for (int i = 0; i < BRAM_MAXW/8; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// bram_rd_pipe: LAT-deep shift register of {valid, data, perr} behind a RAM read port.
// Latency: LAT cycles from in_vld_i to out_vld_o.
// Backpressure: none; shifts every cycle, synchronous clear of all stages on rst.
// Ports: clka/rst; in_vld_i, in_dat_i, in_perr_i (sampled read word); out_vld_o, out_dat_o, out_perr_o.
module bram_rd_pipe #(
    parameter int DW  = 8,
    parameter int LAT = 1
) (
    input  logic          clka,
    input  logic          rst,
    input  logic          in_vld_i,
    input  logic [DW-1:0] in_dat_i,
    input  logic          in_perr_i,
    output logic          out_vld_o,
    output logic [DW-1:0] out_dat_o,
    output logic          out_perr_o
);

    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] perr_q;
    logic [DW-1:0]  dat_q [LAT];

    // Data stages only load behind a valid entry, so the output word holds
    // its last valid value while no read is in flight. perr is carried
    // already qualified by valid, so it can never be 1 without dv.
    always_ff @(posedge clka) begin
        if (rst) begin
            vld_q  <= '0;
            perr_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= in_vld_i;
            perr_q[0] <= in_vld_i & in_perr_i;
            if (in_vld_i) begin
                dat_q[0] <= in_dat_i;
            end
            for (int i = 1; i < LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                perr_q[i] <= perr_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_vld_o  = vld_q[LAT-1];
    assign out_dat_o  = dat_q[LAT-1];
    assign out_perr_o = perr_q[LAT-1];

endmodule

// File: rtl/bram_dp.sv
// bram_dp: true dual-port RAM, both ports on clka, per-byte write enables, read data with dv strobe.
// Latency: read sampled at accept edge T, dout/dv valid after edge T+READ_LAT; writes visible at T+1.
// Backpressure: none; each port accepts one access per cycle whenever cs=1 and rst=0.
// Optional feature macro: BRAM_PARITY_EN (per-byte even parity storage plus a_perr/b_perr).
// Ports: clka, rst (sync, active-high); per port x in {a,b}: x_cs, x_we, x_be[DW/8], x_addr[AW],
//        x_din[DW] in; x_dout[DW], x_dv, x_perr out. Params: DW, AW, READ_LAT (1..3), INIT_FILE.
module bram_dp
    import bram_pkg::*;
#(
    parameter int    DW        = 8,
    parameter int    AW        = 16,
    parameter int    READ_LAT  = 1,
    parameter string INIT_FILE = ""
) (
    input  logic            clka,
    input  logic            rst,
    input  logic            a_cs,
    input  logic            a_we,
    input  logic [DW/8-1:0] a_be,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_din,
    output logic [DW-1:0]   a_dout,
    output logic            a_dv,
    output logic            a_perr,
    input  logic            b_cs,
    input  logic            b_we,
    input  logic [DW/8-1:0] b_be,
    input  logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_din,
    output logic [DW-1:0]   b_dout,
    output logic            b_dv,
    output logic            b_perr
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;
    // Out-of-range READ_LAT values are pulled into the legal window.
    localparam int LAT   = (READ_LAT < BRAM_LAT_MIN) ? BRAM_LAT_MIN :
                           (READ_LAT > BRAM_LAT_MAX) ? BRAM_LAT_MAX : READ_LAT;
`ifdef BRAM_PARITY_EN
    localparam int MW    = DW + NB;   // {parity[NB-1:0], data[DW-1:0]}
`else
    localparam int MW    = DW;
`endif

    logic [MW-1:0] mem [DEPTH];

    // Merge write data into a stored word; parity bits follow their bytes.
    function automatic logic [MW-1:0] wr_word(
        input logic [MW-1:0] old_w,
        input logic [DW-1:0] din,
        input logic [NB-1:0] be
    );
        logic [BRAM_MAXW-1:0]   old_p;
        logic [BRAM_MAXW-1:0]   new_p;
        logic [BRAM_MAXW-1:0]   mrg_p;
        logic [BRAM_MAXW/8-1:0] be_p;
        logic [MW-1:0]          w;
        old_p = '0;
        new_p = '0;
        be_p  = '0;
        old_p[DW-1:0] = old_w[DW-1:0];
        new_p[DW-1:0] = din;
        be_p[NB-1:0]  = be;
        mrg_p = bram_merge(old_p, new_p, be_p);
        w = old_w;
        w[DW-1:0] = mrg_p[DW-1:0];
`ifdef BRAM_PARITY_EN
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                w[DW+i] = bram_parity(din[8*i +: 8]);
            end
        end
`endif
        return w;
    endfunction

    logic a_wr, b_wr, a_rd, b_rd, ww_hit;

    assign a_wr   = a_cs & a_we & ~rst;
    assign b_wr   = b_cs & b_we & ~rst;
    assign a_rd   = a_cs & ~a_we & ~rst;
    assign b_rd   = b_cs & ~b_we & ~rst;
    assign ww_hit = a_wr & b_wr & (a_addr == b_addr);

    // On a double write to one address, B's bytes are merged first and A's
    // on top, so A wins every byte both enable and B keeps its exclusive bytes.
    always_ff @(posedge clka) begin
        if (b_wr && !ww_hit) begin
            mem[b_addr] <= wr_word(mem[b_addr], b_din, b_be);
        end
        if (a_wr) begin
            mem[a_addr] <= wr_word(ww_hit ? wr_word(mem[a_addr], b_din, b_be) : mem[a_addr],
                                   a_din, a_be);
        end
    end

    // Synchronous read sample: the array value before this edge's writes,
    // which gives read-first behaviour on a read/write collision.
    logic          a_rvld_q, b_rvld_q;
    logic [MW-1:0] a_rword_q, b_rword_q;

    always_ff @(posedge clka) begin
        if (rst) begin
            a_rvld_q <= 1'b0;
            b_rvld_q <= 1'b0;
        end else begin
            a_rvld_q <= a_rd;
            b_rvld_q <= b_rd;
        end
        if (a_rd) begin
            a_rword_q <= mem[a_addr];
        end
        if (b_rd) begin
            b_rword_q <= mem[b_addr];
        end
    end

    logic a_rperr, b_rperr;

`ifdef BRAM_PARITY_EN
    function automatic logic word_perr(input logic [MW-1:0] w);
        logic e;
        e = 1'b0;
        for (int i = 0; i < NB; i++) begin
            e = e | (bram_parity(w[8*i +: 8]) != w[DW+i]);
        end
        return e;
    endfunction

    assign a_rperr = word_perr(a_rword_q);
    assign b_rperr = word_perr(b_rword_q);

    task automatic bram_inject_parity(input logic [AW-1:0] addr, input int unsigned byte_idx);
        mem[addr][DW+byte_idx] = ~mem[addr][DW+byte_idx];
    endtask
`else
    assign a_rperr = 1'b0;
    assign b_rperr = 1'b0;
`endif

    bram_rd_pipe #(.DW(DW), .LAT(LAT)) u_pipe_a (
        .clka       (clka),
        .rst        (rst),
        .in_vld_i   (a_rvld_q),
        .in_dat_i   (a_rword_q[DW-1:0]),
        .in_perr_i  (a_rperr),
        .out_vld_o  (a_dv),
        .out_dat_o  (a_dout),
        .out_perr_o (a_perr)
    );

    bram_rd_pipe #(.DW(DW), .LAT(LAT)) u_pipe_b (
        .clka       (clka),
        .rst        (rst),
        .in_vld_i   (b_rvld_q),
        .in_dat_i   (b_rword_q[DW-1:0]),
        .in_perr_i  (b_rperr),
        .out_vld_o  (b_dv),
        .out_dat_o  (b_dout),
        .out_perr_o (b_perr)
    );

endmodule

// File: tb/tb_bram_dp.sv
// tb_bram_dp: directed checks of bram_dp in two configurations (8-bit/LAT 2 and 32-bit/LAT 3).
// Latency: inputs driven on falling edges, accepted on the next rising edge, outputs sampled on falling edges.
// Backpressure: n/a.
module tb_bram_dp;

    logic clka;
    logic rst;

    // u0: DW=8, AW=16, READ_LAT=2
    logic        a0_cs, a0_we, a0_dv, a0_perr;
    logic [0:0]  a0_be;
    logic [15:0] a0_addr;
    logic [7:0]  a0_din, a0_dout;
    logic        b0_cs, b0_we, b0_dv, b0_perr;
    logic [0:0]  b0_be;
    logic [15:0] b0_addr;
    logic [7:0]  b0_din, b0_dout;

    // u1: DW=32, AW=8, READ_LAT=3
    logic        a1_cs, a1_we, a1_dv, a1_perr;
    logic [3:0]  a1_be;
    logic [7:0]  a1_addr;
    logic [31:0] a1_din, a1_dout;
    logic        b1_cs, b1_we, b1_dv, b1_perr;
    logic [3:0]  b1_be;
    logic [7:0]  b1_addr;
    logic [31:0] b1_din, b1_dout;

    int total;
    int bad;

    bram_dp #(.DW(8), .AW(16), .READ_LAT(2), .INIT_FILE("")) u0 (
        .clka(clka), .rst(rst),
        .a_cs(a0_cs), .a_we(a0_we), .a_be(a0_be), .a_addr(a0_addr), .a_din(a0_din),
        .a_dout(a0_dout), .a_dv(a0_dv), .a_perr(a0_perr),
        .b_cs(b0_cs), .b_we(b0_we), .b_be(b0_be), .b_addr(b0_addr), .b_din(b0_din),
        .b_dout(b0_dout), .b_dv(b0_dv), .b_perr(b0_perr)
    );

    bram_dp #(.DW(32), .AW(8), .READ_LAT(3), .INIT_FILE("")) u1 (
        .clka(clka), .rst(rst),
        .a_cs(a1_cs), .a_we(a1_we), .a_be(a1_be), .a_addr(a1_addr), .a_din(a1_din),
        .a_dout(a1_dout), .a_dv(a1_dv), .a_perr(a1_perr),
        .b_cs(b1_cs), .b_we(b1_we), .b_be(b1_be), .b_addr(b1_addr), .b_din(b1_din),
        .b_dout(b1_dout), .b_dv(b1_dv), .b_perr(b1_perr)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic step();
        @(negedge clka);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle0();
        a0_cs = 1'b0; a0_we = 1'b0; a0_be = '0; a0_addr = '0; a0_din = '0;
        b0_cs = 1'b0; b0_we = 1'b0; b0_be = '0; b0_addr = '0; b0_din = '0;
    endtask

    task automatic idle1();
        a1_cs = 1'b0; a1_we = 1'b0; a1_be = '0; a1_addr = '0; a1_din = '0;
        b1_cs = 1'b0; b1_we = 1'b0; b1_be = '0; b1_addr = '0; b1_din = '0;
    endtask

    // u0 read on one port (0=A, 1=B); checks dv timing, data and perr.
    task automatic rd0(input bit port, input logic [15:0] addr, input logic [7:0] exp,
                       input string tag);
        if (port == 1'b0) begin
            a0_cs = 1'b1; a0_we = 1'b0; a0_addr = addr;
        end else begin
            b0_cs = 1'b1; b0_we = 1'b0; b0_addr = addr;
        end
        step();
        idle0();
        step();
        chk({tag, "_dv_early"}, 32'(port ? b0_dv : a0_dv), 32'd0);
        step();
        chk({tag, "_dv"},   32'(port ? b0_dv : a0_dv), 32'd1);
        chk({tag, "_dat"},  32'(port ? b0_dout : a0_dout), 32'(exp));
        chk({tag, "_perr"}, 32'(port ? b0_perr : a0_perr), 32'd0);
    endtask

    task automatic rd1(input bit port, input logic [7:0] addr, input logic [31:0] exp,
                       input string tag);
        if (port == 1'b0) begin
            a1_cs = 1'b1; a1_we = 1'b0; a1_addr = addr;
        end else begin
            b1_cs = 1'b1; b1_we = 1'b0; b1_addr = addr;
        end
        step();
        idle1();
        for (int i = 0; i < 2; i++) begin
            step();
            chk({tag, "_dv_early"}, 32'(port ? b1_dv : a1_dv), 32'd0);
        end
        step();
        chk({tag, "_dv"},   32'(port ? b1_dv : a1_dv), 32'd1);
        chk({tag, "_dat"},  port ? b1_dout : a1_dout, exp);
        chk({tag, "_perr"}, 32'(port ? b1_perr : a1_perr), 32'd0);
    endtask

    task automatic wr1(input bit port, input logic [7:0] addr, input logic [31:0] din,
                       input logic [3:0] be);
        if (port == 1'b0) begin
            a1_cs = 1'b1; a1_we = 1'b1; a1_addr = addr; a1_din = din; a1_be = be;
        end else begin
            b1_cs = 1'b1; b1_we = 1'b1; b1_addr = addr; b1_din = din; b1_be = be;
        end
        step();
        idle1();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle0();
        idle1();
        repeat (3) step();

        // Reset state of every output.
        chk("rst_a0_dout", 32'(a0_dout), 32'd0);
        chk("rst_b0_dout", 32'(b0_dout), 32'd0);
        chk("rst_u0_dv",   32'({a0_dv, b0_dv}), 32'd0);
        chk("rst_u0_perr", 32'({a0_perr, b0_perr}), 32'd0);
        chk("rst_a1_dout", a1_dout, 32'd0);
        chk("rst_b1_dout", b1_dout, 32'd0);
        chk("rst_u1_dv",   32'({a1_dv, b1_dv, a1_perr, b1_perr}), 32'd0);
        rst = 1'b0;
        step();

        // Write on A, read back on B at the very next accept edge.
        a0_cs = 1'b1; a0_we = 1'b1; a0_be = 1'b1; a0_addr = 16'h1234; a0_din = 8'hA5;
        step();
        idle0();
        chk("wr_no_dv", 32'(a0_dv), 32'd0);
        rd0(1'b1, 16'h1234, 8'hA5, "a_to_b");
        step();
        chk("hold_dv",  32'(b0_dv), 32'd0);
        chk("hold_dat", 32'(b0_dout), 32'hA5);

        // A write with no byte enables leaves the word alone.
        a0_cs = 1'b1; a0_we = 1'b1; a0_be = 1'b0; a0_addr = 16'h1234; a0_din = 8'h99;
        step();
        idle0();
        rd0(1'b0, 16'h1234, 8'hA5, "be0_noop");

        // Write/write collision: A wins.
        a0_cs = 1'b1; a0_we = 1'b1; a0_be = 1'b1; a0_addr = 16'h0010; a0_din = 8'h55;
        b0_cs = 1'b1; b0_we = 1'b1; b0_be = 1'b1; b0_addr = 16'h0010; b0_din = 8'h66;
        step();
        idle0();
        rd0(1'b0, 16'h0010, 8'h55, "ww_a_wins");

        // Read/write collision: B sees the old word, later read sees the new one.
        b0_cs = 1'b1; b0_we = 1'b0; b0_addr = 16'h0010;
        a0_cs = 1'b1; a0_we = 1'b1; a0_be = 1'b1; a0_addr = 16'h0010; a0_din = 8'h77;
        step();
        idle0();
        step();
        chk("rw_dv_early", 32'(b0_dv), 32'd0);
        step();
        chk("rw_dv",  32'(b0_dv), 32'd1);
        chk("rw_old", 32'(b0_dout), 32'h55);
        rd0(1'b0, 16'h0010, 8'h77, "rw_new");

        // Back-to-back reads stream one word per cycle.
        a0_cs = 1'b1; a0_we = 1'b0; a0_addr = 16'h1234;
        step();
        a0_addr = 16'h0010;
        step();
        idle0();
        step();
        chk("stream_dv0",  32'(a0_dv), 32'd1);
        chk("stream_dat0", 32'(a0_dout), 32'hA5);
        step();
        chk("stream_dv1",  32'(a0_dv), 32'd1);
        chk("stream_dat1", 32'(a0_dout), 32'h77);
        step();
        chk("stream_end",  32'(a0_dv), 32'd0);

        // 32-bit byte-enable merge.
        wr1(1'b0, 8'h20, 32'h11223344, 4'b1111);
        wr1(1'b0, 8'h20, 32'hAABBCCDD, 4'b0101);
        rd1(1'b0, 8'h20, 32'h11BB33DD, "be_merge");

        // Both ports read the same word.
        a1_cs = 1'b1; a1_we = 1'b0; a1_addr = 8'h20;
        b1_cs = 1'b1; b1_we = 1'b0; b1_addr = 8'h20;
        step();
        idle1();
        step();
        step();
        chk("rr_dv_early", 32'({a1_dv, b1_dv}), 32'd0);
        step();
        chk("rr_dv",  32'({a1_dv, b1_dv}), 32'd3);
        chk("rr_a",   a1_dout, 32'h11BB33DD);
        chk("rr_b",   b1_dout, 32'h11BB33DD);

        // Partially overlapping double write: A wins shared bytes, B keeps its own.
        wr1(1'b0, 8'h30, 32'h00000000, 4'b1111);
        a1_cs = 1'b1; a1_we = 1'b1; a1_be = 4'b0011; a1_addr = 8'h30; a1_din = 32'hA1A2A3A4;
        b1_cs = 1'b1; b1_we = 1'b1; b1_be = 4'b0110; b1_addr = 8'h30; b1_din = 32'hB1B2B3B4;
        step();
        idle1();
        rd1(1'b1, 8'h30, 32'h00B2A3A4, "ww_partial");

        // Reset drops in-flight reads, blocks accesses, keeps contents.
        a1_cs = 1'b1; a1_we = 1'b1; a1_be = 4'hF; a1_addr = 8'h40; a1_din = 32'hCAFE0001;
        b1_cs = 1'b1; b1_we = 1'b1; b1_be = 4'hF; b1_addr = 8'h41; b1_din = 32'hCAFE0002;
        step();
        idle1();
        wr1(1'b0, 8'h42, 32'hCAFE0003, 4'hF);
        a1_cs = 1'b1; a1_we = 1'b0; a1_addr = 8'h40;
        step();
        a1_addr = 8'h41;
        step();
        a1_addr = 8'h42;
        step();
        chk("pre_rst_dv", 32'(a1_dv), 32'd0);
        rst = 1'b1;
        a1_addr = 8'h40;
        b1_cs = 1'b1; b1_we = 1'b1; b1_be = 4'hF; b1_addr = 8'h40; b1_din = 32'hDEADBEEF;
        step();
        chk("rst_flush_dv",   32'({a1_dv, b1_dv}), 32'd0);
        chk("rst_flush_dout", a1_dout, 32'd0);
        chk("rst_flush_perr", 32'({a1_perr, b1_perr}), 32'd0);
        step();
        rst = 1'b0;
        idle1();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_no_dv", 32'({a1_dv, b1_dv}), 32'd0);
            chk("post_rst_dout",  a1_dout, 32'd0);
        end
        rd1(1'b0, 8'h40, 32'hCAFE0001, "kept_40");
        rd1(1'b1, 8'h41, 32'hCAFE0002, "kept_41");
        rd1(1'b0, 8'h42, 32'hCAFE0003, "kept_42");

`ifdef BRAM_PARITY_EN
        // Corrupted parity is flagged with dv; a rewrite repairs it.
        a0_cs = 1'b1; a0_we = 1'b1; a0_be = 1'b1; a0_addr = 16'h0005; a0_din = 8'h3C;
        step();
        idle0();
        u0.bram_inject_parity(16'h0005, 0);
        a0_cs = 1'b1; a0_we = 1'b0; a0_addr = 16'h0005;
        step();
        idle0();
        step();
        chk("perr_early", 32'(a0_perr), 32'd0);
        step();
        chk("perr_dv",  32'(a0_dv), 32'd1);
        chk("perr_set", 32'(a0_perr), 32'd1);
        chk("perr_dat", 32'(a0_dout), 32'h3C);
        step();
        chk("perr_clr_no_dv", 32'(a0_perr), 32'd0);
        a0_cs = 1'b1; a0_we = 1'b1; a0_be = 1'b1; a0_addr = 16'h0005; a0_din = 8'h3C;
        step();
        idle0();
        rd0(1'b0, 16'h0005, 8'h3C, "perr_fixed");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
